// File: rtl/ion_sensor_arbiter_pkg.sv
// Shared constants and FSM encoding for the ion sensor arbiter.
package ion_sensor_arbiter_pkg;

  localparam int unsigned NUM_STREAMS  = 8;
  localparam int unsigned STREAM_IDX_W = 3;
  localparam int unsigned TIMEOUT_W    = 16;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_DEFAULT = 16'd5000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } isa_state_e;

endpackage

// File: rtl/ion_sensor_arbiter_if.sv
// Request/grant and sensor handshake bundle between the sample streams and the arbiter.
interface ion_sensor_arbiter_if;
  import ion_sensor_arbiter_pkg::*;

  logic [NUM_STREAMS-1:0]  i_s_request;
  logic [NUM_STREAMS-1:0]  stream_active;
  logic                    sensor_ready;
  logic                    sensor_done;
  logic                    sensor_start;
  logic [STREAM_IDX_W-1:0] sensor_sel;
  logic [NUM_STREAMS-1:0]  grant;
  logic [NUM_STREAMS-1:0]  pending;
  logic [NUM_STREAMS-1:0]  overrun;
  logic                    timeout_err;

  modport slave (
    input  i_s_request, stream_active, sensor_ready, sensor_done,
    output sensor_start, sensor_sel, grant, pending, overrun, timeout_err
  );

  modport master (
    output i_s_request, stream_active, sensor_ready, sensor_done,
    input  sensor_start, sensor_sel, grant, pending, overrun, timeout_err
  );

endinterface

// File: rtl/ion_sensor_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request searching upward from last+1 (mod 8).
module rr_priority_picker
  import ion_sensor_arbiter_pkg::*;
(
  input  logic [NUM_STREAMS-1:0]  req,
  input  logic [STREAM_IDX_W-1:0] last,
  output logic [NUM_STREAMS-1:0]  onehot,
  output logic [STREAM_IDX_W-1:0] idx,
  output logic                    valid
);

  logic [STREAM_IDX_W-1:0] cand;

  // Offset 8 wraps to 'last' itself, so the previous winner is considered last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_STREAMS; i++) begin
      cand = last + STREAM_IDX_W'(i);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ion_sensor_arbiter.sv
// Round-robin arbiter sharing one ion sensor among eight sample streams.
// Optional WAIT timeout is enabled by defining ISA_TIMEOUT_EN.
module ion_sensor_arbiter
  import ion_sensor_arbiter_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                 clock,
  input logic                 resetn,
  ion_sensor_arbiter_if.slave bus
);

  isa_state_e              state_q, state_d;
  logic [NUM_STREAMS-1:0]  grant_q, grant_d;
  logic [NUM_STREAMS-1:0]  pending_q, pending_d;
  logic [NUM_STREAMS-1:0]  overrun_q, overrun_d;
  logic [STREAM_IDX_W-1:0] sel_q, sel_d;
  logic [STREAM_IDX_W-1:0] last_q, last_d;
  logic                    start_q, start_d;
  logic                    load;

  logic [NUM_STREAMS-1:0]  eligible;
  logic [NUM_STREAMS-1:0]  pick_grant;
  logic [STREAM_IDX_W-1:0] pick_idx;
  logic                    pick_valid;

`ifdef ISA_TIMEOUT_EN
  // A zero TIMEOUT behaves as one cycle.
  localparam logic [TIMEOUT_W-1:0] TMO_LIMIT =
    (TIMEOUT == '0) ? '0 : TIMEOUT - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 tmo_err_q, tmo_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Flushed streams are masked so a stale pending bit is never granted.
  assign eligible = pending_q & bus.stream_active;

  rr_priority_picker u_picker (
    .req    (eligible),
    .last   (last_q),
    .onehot (pick_grant),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Next state and registered-output values.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    start_d = 1'b0;
    load    = 1'b0;
`ifdef ISA_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid && bus.sensor_ready) begin
          state_d = ST_ISSUE;
          grant_d = pick_grant;
          sel_d   = pick_idx;
          start_d = 1'b1;
          load    = 1'b1;
`ifdef ISA_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef ISA_TIMEOUT_EN
        if (cnt_q == TMO_LIMIT) tmo_err_d = 1'b1;
        else                    cnt_d     = cnt_q + TIMEOUT_W'(1);
`endif
      end
      ST_WAIT: begin
`ifdef ISA_TIMEOUT_EN
        // The error pulse is registered one cycle ahead so that done in the
        // deciding cycle still suppresses it; WAIT then exits on the pulse.
        if (bus.sensor_done || tmo_err_q) state_d   = ST_RELEASE;
        else if (cnt_q == TMO_LIMIT)      tmo_err_d = 1'b1;
        else                              cnt_d     = cnt_q + TIMEOUT_W'(1);
`else
        if (bus.sensor_done) state_d = ST_RELEASE;
`endif
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        last_d  = sel_q;
        grant_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-stream pending/overrun update; flush dominates, then overrun, then grant.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
      if (!bus.stream_active[k]) begin
        pending_d[k] = 1'b0;
        overrun_d[k] = 1'b0;
      end else if (bus.i_s_request[k]) begin
        if (pending_q[k]) overrun_d[k] = 1'b1;
        pending_d[k] = 1'b1;
      end else if (load && pick_grant[k]) begin
        pending_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      grant_q   <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      sel_q     <= '0;
      last_q    <= STREAM_IDX_W'(NUM_STREAMS - 1);
      start_q   <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      start_q   <= start_d;
    end
  end

`ifdef ISA_TIMEOUT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.sensor_start = start_q;
  assign bus.sensor_sel   = sel_q;
  assign bus.grant        = grant_q;
  assign bus.pending      = pending_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: doc/ion_sensor_arbiter.md
# ion_sensor_arbiter

Shares the single ion sensor between the eight periodic sample streams. It latches the one-cycle request pulses from the per-stream request generators and grants the sensor to one stream at a time, in round-robin order. For each grant it issues a start pulse with the stream index, holds the grant until the sensor reports completion or a timeout expires, and flags requests that were lost to overrun.

## Interface
- TIMEOUT, 16'd5000: maximum WAIT cycles per transaction; 0 is treated as 1
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- i_s_request  in  8  per-stream request pulses, one cycle wide
- stream_active  in  8  stream enables; a low bit flushes that stream's state
- sensor_ready  in  1  sensor idle and able to accept a start
- sensor_done  in  1  one-cycle completion pulse from the sensor
- sensor_start  out  1  one-cycle start pulse to the sensor
- sensor_sel  out  3  index of the granted stream, held from ISSUE through RELEASE
- grant  out  8  one-hot grant, held from ISSUE through RELEASE
- pending  out  8  latched, not-yet-granted requests
- overrun  out  8  sticky per stream: a request arrived while already pending
- timeout_err  out  1  one-cycle pulse when a transaction times out

## Operation
- Reset values: state IDLE, pending 0, overrun 0, grant 0, sensor_sel 0, sensor_start 0, timeout_err 0, last-served pointer 7 (stream 0 wins first), timeout counter 0.
- pending[k] update, in priority order:
  - stream_active[k]=0: pending[k] and overrun[k] clear. This dominates a request in the same cycle.
  - i_s_request[k]=1 while pending[k]=1: set overrun[k]; pending stays 1.
  - i_s_request[k]=1 on the same edge that grants stream k: pending[k] stays set for the next round.
  - Otherwise the grant edge clears pending[k].
- Round-robin pick: first set bit of pending, searching from last+1 modulo 8 upward.
- State machine:
  - IDLE: go to ISSUE when pending≠0 and sensor_ready=1. On that edge, load grant and sensor_sel and clear the chosen pending bit.
  - ISSUE: sensor_start=1 for exactly this cycle. Always go to WAIT; clear the timeout counter.
  - WAIT: on sensor_done, go to RELEASE. With ISA_TIMEOUT_EN, when the counter reaches TIMEOUT-1 without done, pulse timeout_err and go to RELEASE. Otherwise the counter increments.
  - RELEASE: last := sensor_sel. Go to IDLE; grant clears on exit.
- sensor_done and timeout in the same cycle: done wins, no timeout_err.
- sensor_done outside WAIT is ignored.
- stream_active[k] dropping during k's transaction does not abort it; the transaction completes normally.
- Counter is 16 bits and never wraps; it stops at the compare.
- Asynchronous reset mid-transaction returns all outputs to reset values immediately. Any in-flight sensor cycle is abandoned.

## Timing
- Request pulse in cycle 0 → pending visible in cycle 1 → ISSUE with grant, sel and sensor_start in cycle 2. Minimum latency is 2 cycles; more if the sensor is busy or other streams win arbitration.
- sensor_done in cycle d → RELEASE in d+1 → IDLE in d+2 → earliest next sensor_start in d+3.
- Timeout: sensor_start in cycle s → timeout_err in cycle s+TIMEOUT → RELEASE in s+TIMEOUT+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- ISA_TIMEOUT_EN defined: timeout counter present, timeout_err active.
- ISA_TIMEOUT_EN undefined: WAIT exits only on sensor_done, no counter is synthesized, timeout_err is tied 0, and TIMEOUT is unused.

## Structure
- Shared package/header holds:
  - NUM_STREAMS=8 and STREAM_IDX_W=3
  - ISA state encoding: IDLE, ISSUE, WAIT, RELEASE
  - TIMEOUT default constant
- One sub-module, rr_priority_picker: combinational. Takes the 8-bit request vector and 3-bit last pointer; returns a one-hot grant, a 3-bit index and a valid flag.
- The FSM, pending/overrun registers and counter live in the top.

## Test plan
- Reset, then a single request on stream 3 → pending[3] in cycle 1; sensor_start, grant=8'h08 and sel=3 in cycle 2; done 10 cycles later → grant=0 two cycles after done.
- Requests on streams 0, 2 and 5 in the same cycle with immediate done responses → grants in order 0, 2, 5. Then a re-request on 0 and 5 with last=5 → 0 served first.
- Second request on stream 1 while pending[1]=1 → overrun[1]=1, sticky. Deasserting stream_active[1] clears both pending[1] and overrun[1].
- With ISA_TIMEOUT_EN and TIMEOUT=4, no done → timeout_err exactly 4 cycles after sensor_start, then IDLE. With done and timeout in the same cycle → no timeout_err.
- sensor_ready=0 with pending=8'hFF → no sensor_start. Raising ready → grant to stream 0 on the next edge.
- resetn pulsed low during WAIT → all outputs 0 asynchronously; after release, last=7 and the first grant goes to the lowest pending stream.
